// File: rtl/als_pkg.sv
// -----------------------------------------------------------------------------
// als_pkg
// Shared constants for the PmodALS light-sensor SPI link, used by both the
// emulator (als_sensor_emulator) and the ALS SPI master.
//   ALS_LEAD_ZEROS / ALS_DATA_W / ALS_TRAIL_ZEROS : frame layout
//   ALS_FRAME_LEN                                  : total bits per frame
//   ALS_SYNC_STAGES                                : input synchronizer depth
//   als_emu_state_e                                : emulator state encoding
// -----------------------------------------------------------------------------
package als_pkg;

    localparam int ALS_LEAD_ZEROS  = 4;
    localparam int ALS_DATA_W      = 8;
    localparam int ALS_TRAIL_ZEROS = 4;
    localparam int ALS_FRAME_LEN   = ALS_LEAD_ZEROS + ALS_DATA_W + ALS_TRAIL_ZEROS;
    localparam int ALS_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ALS_IDLE   = 2'd0,
        ALS_ACTIVE = 2'd1,
        ALS_HOLD   = 2'd2
    } als_emu_state_e;

endpackage

// File: rtl/als_sensor_emulator_spi_input_sync.sv
// -----------------------------------------------------------------------------
// spi_input_sync
// Brings one asynchronous SPI pin into the clk domain through a SYNC_STAGES
// flop chain and produces single-cycle edge pulses on the synchronized level.
// Ports:
//   i_clk, i_reset : system clock, synchronous active-high reset
//   i_async        : raw pin
//   o_level        : synchronized level
//   o_rise/o_fall  : 1-cycle pulses on synchronized rising/falling edges
// Parameters:
//   SYNC_STAGES : chain depth (>= 2)
//   RESET_VAL   : idle level of the pin; chain and edge history preset to it
// -----------------------------------------------------------------------------
module spi_input_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // NOTE: non-blocking assignments let every flop sample its predecessor's
    // old value, which is what makes this a chain rather than one wire.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  o_level & ~r_prev;
    assign o_fall  = ~o_level &  r_prev;

endmodule

// File: rtl/als_sensor_emulator.sv
// -----------------------------------------------------------------------------
// als_sensor_emulator
// SPI responder modelling the PmodALS light sensor. Each frame driven by the
// master returns {LEAD_ZEROS zeros, sample, TRAIL_ZEROS zeros} MSB first on
// o_miso, changing on sclk falling edges. cs_n and sclk are asynchronous and
// are synchronized internally.
// Ports:
//   i_clk, i_reset      : system clock, synchronous active-high reset
//   i_sample_in         : value served by the next frame
//   i_sample_valid      : 1-cycle strobe loading i_sample_in into the pending reg
//   i_cs_n, i_sclk      : SPI chip select (active low) and serial clock
//   o_miso              : serial data to master
//   o_busy              : frame in progress (ACTIVE or HOLD)
//   o_frame_done        : 1-cycle pulse, frame closed after all bits
//   o_frame_abort       : 1-cycle pulse, frame closed early
//   o_frame_count       : completed frames, wraps at 0xFFFF
// Configuration macro:
//   ALS_EMU_TRISTATE_EN : when defined, o_miso floats while cs_n is high so the
//                         line can be shared; otherwise it is driven 0 in IDLE.
// -----------------------------------------------------------------------------
module als_sensor_emulator
    import als_pkg::*;
#(
    parameter int DATA_W      = ALS_DATA_W,
    parameter int LEAD_ZEROS  = ALS_LEAD_ZEROS,
    parameter int TRAIL_ZEROS = ALS_TRAIL_ZEROS,
    parameter int SYNC_STAGES = ALS_SYNC_STAGES
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_sample_in,
    input  logic              i_sample_valid,
    input  logic              i_cs_n,
    input  logic              i_sclk,
    output logic              o_miso,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_frame_abort,
    output logic [15:0]       o_frame_count
);

    localparam int FRAME_LEN = LEAD_ZEROS + DATA_W + TRAIL_ZEROS;
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam int SETTLE_W  = $clog2(SYNC_STAGES + 1);
    // The shift that moves bit_cnt onto the last bit is the one taken from here.
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(FRAME_LEN - 2);

    // ---------------------------------------------------------------- inputs
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_sclk_fall, w_unused_sclk_level, w_unused_sclk_rise;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_cs_n),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // Only falling sclk edges matter here; the master samples on the rises.
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_sclk),
        .o_level (w_unused_sclk_level),
        .o_rise  (w_unused_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // ------------------------------------------------------- start qualifier
    // The cs_n synchronizer is preset high, so a pin held low through reset
    // would otherwise look like a fresh falling edge once the chain fills.
    // A frame may only start after cs_n has been seen high with a settled chain.
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic                r_cs_armed;
    logic                w_settled;
    logic                w_start;

    assign w_settled = (r_settle_cnt == SETTLE_W'(SYNC_STAGES));
    assign w_start   = w_cs_fall & r_cs_armed;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_settle_cnt <= '0;
            r_cs_armed   <= 1'b0;
        end else begin
            if (!w_settled)
                r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
            if (w_settled && w_cs_level)
                r_cs_armed <= 1'b1;
        end
    end

    // -------------------------------------------------------- pending sample
    logic [DATA_W-1:0]    r_pending;
    logic [DATA_W-1:0]    w_frame_data;
    logic [FRAME_LEN-1:0] w_frame;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_pending <= '0;
        else if (i_sample_valid)
            r_pending <= i_sample_in;
    end

    // A strobe landing on the same cycle as the start is the value framed.
    assign w_frame_data = i_sample_valid ? i_sample_in : r_pending;
    assign w_frame      = {{LEAD_ZEROS{1'b0}}, w_frame_data, {TRAIL_ZEROS{1'b0}}};

    // ------------------------------------------------------------------- FSM
    als_emu_state_e r_state, w_state_nxt;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= ALS_IDLE;
        else
            r_state <= w_state_nxt;
    end

    logic [FRAME_LEN-1:0] r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;

    // cs_n rise is tested before sclk fall so it wins when both coincide.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ALS_IDLE: begin
                if (w_start)
                    w_state_nxt = ALS_ACTIVE;
            end
            ALS_ACTIVE: begin
                if (w_cs_rise)
                    w_state_nxt = ALS_IDLE;
                else if (w_sclk_fall && r_bit_cnt == LAST_SHIFT)
                    w_state_nxt = ALS_HOLD;
            end
            ALS_HOLD: begin
                if (w_cs_rise)
                    w_state_nxt = ALS_IDLE;
            end
            default: w_state_nxt = ALS_IDLE;
        endcase
    end

    logic                 r_miso, r_busy, r_done, r_abort;
    logic [15:0]          r_frame_count;
    logic [FRAME_LEN-1:0] w_shift_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_miso_nxt, w_done_nxt, w_abort_nxt;

    // NOTE: every output of this block gets a value before the case statement,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_bit_cnt;
        w_miso_nxt  = r_miso;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
        case (r_state)
            ALS_IDLE: begin
                w_miso_nxt = 1'b0;
                if (w_start) begin
                    w_shift_nxt = w_frame;
                    w_miso_nxt  = w_frame[FRAME_LEN-1];
                    w_cnt_nxt   = '0;
                end
            end
            ALS_ACTIVE: begin
                if (w_cs_rise) begin
                    w_abort_nxt = 1'b1;
                    w_miso_nxt  = 1'b0;
                end else if (w_sclk_fall) begin
                    w_shift_nxt = {r_shift[FRAME_LEN-2:0], 1'b0};
                    w_miso_nxt  = r_shift[FRAME_LEN-2];
                    w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
                end
            end
            ALS_HOLD: begin
                if (w_cs_rise) begin
                    w_done_nxt = 1'b1;
                    w_miso_nxt = 1'b0;
                end else if (w_sclk_fall) begin
                    // Master is over-clocking the frame: pad with zeros.
                    w_miso_nxt = 1'b0;
                end
            end
            default: w_miso_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_miso        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_abort       <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_miso    <= w_miso_nxt;
            r_busy    <= (w_state_nxt != ALS_IDLE);
            r_done    <= w_done_nxt;
            r_abort   <= w_abort_nxt;
            if (w_done_nxt)
                r_frame_count <= r_frame_count + 16'd1;
        end
    end

    // --------------------------------------------------------------- outputs
`ifdef ALS_EMU_TRISTATE_EN
    assign o_miso = w_cs_level ? 1'bz : r_miso;
`else
    assign o_miso = r_miso;
`endif
    assign o_busy        = r_busy;
    assign o_frame_done  = r_done;
    assign o_frame_abort = r_abort;
    assign o_frame_count = r_frame_count;

endmodule
